mdu_ctrl: RTL and testbench

//  Multiply/divide unit controller for the 5-stage MIPS pipeline, placed in the EX stage.

---
 rtl/mdu_ctrl_pkg.sv | 30 +++
 rtl/mdu_ctrl_if.sv | 26 ++
 rtl/mdu_ctrl_arith.sv | 68 ++++++
 rtl/mdu_ctrl.sv | 95 +++++++++
 tb/tb_mdu_ctrl.sv | 156 +++++++++++++++
 5 files changed

// File: rtl/mdu_ctrl_pkg.sv
// Shared definitions for the multiply/divide unit: operation encodings,
// controller states and the arithmetic result payload.
package mdu_ctrl_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        MD_MULT  = 2'd0,
        MD_MULTU = 2'd1,
        MD_DIV   = 2'd2,
        MD_DIVU  = 2'd3
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_e;

    // Result of one MD operation as produced by the arithmetic block.
    typedef struct packed {
        logic [XLEN-1:0] hi;
        logic [XLEN-1:0] lo;
        logic            div_zero;
    } md_res_t;

    function automatic logic is_div(input md_op_e op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/mdu_ctrl_if.sv
// Multiply/divide unit request/response bundle.
//   start, md_op, wr_hi, wr_lo, a, b : requests from the EX stage
//   busy, hi, lo                     : unit status and architectural HI/LO
interface mdu_ctrl_if;
    import mdu_ctrl_pkg::*;

    logic            start;
    md_op_e          md_op;
    logic            wr_hi;
    logic            wr_lo;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            busy;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;

    modport master (
        output start, md_op, wr_hi, wr_lo, a, b,
        input  busy, hi, lo
    );

    modport slave (
        input  start, md_op, wr_hi, wr_lo, a, b,
        output busy, hi, lo
    );
endinterface

// File: rtl/mdu_ctrl_arith.sv
// Combinational multiply/divide datapath.
//   a, b   : rs/rt operands
//   md_op  : operation select
//   res_c  : {hi, lo, div_zero} for the selected operation
module mdu_ctrl_arith
    import mdu_ctrl_pkg::*;
(
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  md_op_e          md_op,
    output md_res_t         res_c
);

    logic signed [2*XLEN-1:0] a_sx;
    logic signed [2*XLEN-1:0] b_sx;
    logic signed [2*XLEN-1:0] prod_s;
    logic        [2*XLEN-1:0] prod_u;
    logic                     div_ovf;
    logic        [XLEN-1:0]   divisor;
    logic signed [XLEN-1:0]   quot_s;
    logic signed [XLEN-1:0]   rem_s;
    logic        [XLEN-1:0]   quot_u;
    logic        [XLEN-1:0]   rem_u;

    assign a_sx   = {{XLEN{a[XLEN-1]}}, a};
    assign b_sx   = {{XLEN{b[XLEN-1]}}, b};
    assign prod_s = a_sx * b_sx;
    assign prod_u = (2*XLEN)'(a) * (2*XLEN)'(b);

    // Most-negative / -1 overflows; its result is forced below, so keep the
    // divider away from both that case and divide-by-zero.
    assign div_ovf = (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == {XLEN{1'b1}});
    assign divisor = ((b == '0) || div_ovf) ? XLEN'(1) : b;
    assign quot_s  = signed'(a) / signed'(divisor);
    assign rem_s   = signed'(a) % signed'(divisor);
    assign quot_u  = a / divisor;
    assign rem_u   = a % divisor;

    // Select the result for the requested operation.
    always_comb begin
        res_c          = '0;
        res_c.div_zero = is_div(md_op) && (b == '0);
        case (md_op)
            MD_MULT: begin
                res_c.hi = prod_s[2*XLEN-1:XLEN];
                res_c.lo = prod_s[XLEN-1:0];
            end
            MD_MULTU: begin
                res_c.hi = prod_u[2*XLEN-1:XLEN];
                res_c.lo = prod_u[XLEN-1:0];
            end
            MD_DIV: begin
                if (div_ovf) begin
                    res_c.hi = '0;
                    res_c.lo = {1'b1, {(XLEN-1){1'b0}}};
                end else begin
                    res_c.hi = rem_s;
                    res_c.lo = quot_s;
                end
            end
            default: begin
                res_c.hi = rem_u;
                res_c.lo = quot_u;
            end
        endcase
    end

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide unit controller (EX stage). Sequences a fixed-latency
// busy window per MD operation and owns the architectural HI/LO registers.
//   clk, reset : clock, synchronous active-high reset
//   mdu        : request/status bundle (slave side)
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       reset,
    mdu_ctrl_if.slave  mdu
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    mdu_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    md_res_t         pend_q, pend_d;
    logic [XLEN-1:0] hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic            busy_q, busy_d;
    md_res_t         res_c;

    mdu_ctrl_arith u_arith (
        .a     (mdu.a),
        .b     (mdu.b),
        .md_op (mdu.md_op),
        .res_c (res_c)
    );

    // State and architectural registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            pend_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state: launch from IDLE, count down in RUN, commit on the last edge.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        busy_d  = busy_q;
        case (state_q)
            ST_IDLE: begin
                if (mdu.start) begin
                    pend_d  = res_c;
                    cnt_d   = is_div(mdu.md_op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                    state_d = ST_RUN;
                    busy_d  = 1'b1;
                end else begin
                    // MTHI/MTLO only when no operation is launched this cycle
                    if (mdu.wr_hi) hi_d = mdu.a;
                    if (mdu.wr_lo) lo_d = mdu.a;
                end
            end
            ST_RUN: begin
                if (cnt_q == CNT_W'(1)) begin
                    if (!pend_q.div_zero) begin
                        hi_d = pend_q.hi;
                        lo_d = pend_q.lo;
                    end
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign mdu.busy = busy_q;
    assign mdu.hi   = hi_q;
    assign mdu.lo   = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed self-checking bench for mdu_ctrl.
module tb_mdu_ctrl;
    import mdu_ctrl_pkg::*;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    mdu_ctrl_if mif ();

    mdu_ctrl #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .mdu   (mif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // Launch an op, check busy and held HI/LO every busy cycle, then the result.
    // inj: 0 none, 1 extra DIV start at T+3, 2 MTLO at T+3. col_wr: MTHI with start.
    task automatic run_op(input string tag, input md_op_e op, input logic [31:0] ia,
                          input logic [31:0] ib, input int n,
                          input logic [31:0] oh, input logic [31:0] ol,
                          input logic [31:0] eh, input logic [31:0] el,
                          input int inj, input logic col_wr);
        mif.start = 1'b1;
        mif.md_op = op;
        mif.a     = ia;
        mif.b     = ib;
        mif.wr_hi = col_wr;
        tick();
        mif.start = 1'b0;
        mif.wr_hi = 1'b0;
        mif.a     = 32'h5A5A_5A5A;
        mif.b     = 32'h0;
        for (int i = 1; i <= n; i++) begin
            check({tag, "_busy"}, 32'(mif.busy), 32'd1);
            check({tag, "_hi_hold"}, mif.hi, oh);
            check({tag, "_lo_hold"}, mif.lo, ol);
            if (i == 3 && inj == 1) begin
                mif.start = 1'b1;
                mif.md_op = MD_DIV;
                mif.a     = 32'd10;
                mif.b     = 32'd2;
            end
            if (i == 3 && inj == 2) begin
                mif.wr_lo = 1'b1;
                mif.a     = 32'hDEAD_0000;
            end
            tick();
            mif.start = 1'b0;
            mif.wr_lo = 1'b0;
        end
        check({tag, "_busy_done"}, 32'(mif.busy), 32'd0);
        check({tag, "_hi"}, mif.hi, eh);
        check({tag, "_lo"}, mif.lo, el);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        reset     = 1'b1;
        mif.start = 1'b0;
        mif.md_op = MD_MULT;
        mif.wr_hi = 1'b0;
        mif.wr_lo = 1'b0;
        mif.a     = '0;
        mif.b     = '0;
        tick();
        tick();
        check("rst_busy", 32'(mif.busy), 32'd0);
        check("rst_hi", mif.hi, 32'd0);
        check("rst_lo", mif.lo, 32'd0);
        reset = 1'b0;
        tick();

        run_op("mult", MD_MULT, 32'hFFFF_FFFE, 32'd3, 5, 32'd0, 32'd0,
               32'hFFFF_FFFF, 32'hFFFF_FFFA, 0, 1'b0);
        run_op("divu", MD_DIVU, 32'd100, 32'd7, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFA,
               32'd2, 32'd14, 0, 1'b0);
        run_op("div", MD_DIV, 32'hFFFF_FFF9, 32'd2, 10, 32'd2, 32'd14,
               32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, 1'b0);

        mif.wr_hi = 1'b1;
        mif.a     = 32'h1234_5678;
        tick();
        mif.wr_hi = 1'b0;
        check("mthi_hi", mif.hi, 32'h1234_5678);
        check("mthi_lo", mif.lo, 32'hFFFF_FFFD);

        run_op("mult_mtlo", MD_MULT, 32'd3, 32'd4, 5, 32'h1234_5678, 32'hFFFF_FFFD,
               32'd0, 32'd12, 2, 1'b0);
        run_op("multu_restart", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 32'd0, 32'd12,
               32'hFFFF_FFFE, 32'd1, 1, 1'b0);

        mif.wr_hi = 1'b1;
        mif.wr_lo = 1'b1;
        mif.a     = 32'hAAAA_5555;
        tick();
        mif.wr_hi = 1'b0;
        mif.wr_lo = 1'b0;
        check("mtboth_hi", mif.hi, 32'hAAAA_5555);
        check("mtboth_lo", mif.lo, 32'hAAAA_5555);

        run_op("div_zero", MD_DIV, 32'd5, 32'd0, 10, 32'hAAAA_5555, 32'hAAAA_5555,
               32'hAAAA_5555, 32'hAAAA_5555, 0, 1'b0);
        run_op("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'hAAAA_5555,
               32'hAAAA_5555, 32'd0, 32'h8000_0000, 0, 1'b0);
        run_op("start_vs_mthi", MD_MULTU, 32'd2, 32'd3, 5, 32'd0, 32'h8000_0000,
               32'd0, 32'd6, 0, 1'b1);
        run_op("b2b_divu", MD_DIVU, 32'd9, 32'd2, 10, 32'd0, 32'd6,
               32'd1, 32'd4, 0, 1'b0);

        mif.start = 1'b1;
        mif.md_op = MD_DIV;
        mif.a     = 32'd100;
        mif.b     = 32'd7;
        tick();
        mif.start = 1'b0;
        tick();
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_busy", 32'(mif.busy), 32'd0);
        check("abort_hi", mif.hi, 32'd0);
        check("abort_lo", mif.lo, 32'd0);
        repeat (12) tick();
        check("abort_busy_late", 32'(mif.busy), 32'd0);
        check("abort_hi_late", mif.hi, 32'd0);
        check("abort_lo_late", mif.lo, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
